connection_block_gen: RTL
=========================

CONNECTION_BLOCK_GEN -- requirements
Module: connection_block_gen

Parameters
REQ-001 The block SHALL have parameter W, default 4, giving the number of routing tracks (W >= 2, power of two).
REQ-002 The block SHALL have parameter K, default 2, giving the number of logic-block inputs driven from the tracks (K >= 1).
REQ-003 The block SHALL derive SW = log2(W), the per-input select width, and CFG_BITS = K*(SW+1) + W, the configuration length (10 at defaults).

Interface
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  W  routing track values.
REQ-007 z  input  1  logic-block output, drivable onto tracks.
REQ-008 out  output  W  track outputs.
REQ-009 I  output  K  logic-block inputs.
REQ-010 cfg_valid  input  1  qualifies cfg_bit for one shift.
REQ-011 cfg_bit  input  1  serial configuration data.
REQ-012 cfg_commit  input  1  request to copy shadow config to active config.
REQ-013 cfg_clear  input  1  discard the shadow config and restart loading.
REQ-014 cfg_out  output  1  shadow MSB, for daisy-chaining blocks.
REQ-015 cfg_done  output  1  one-cycle pulse when a commit takes effect.
REQ-016 cfg_err  output  1  one-cycle pulse when a commit is rejected.

Function
REQ-017 On each accepted shift, the shadow register SHALL update as shadow <= {shadow[CFG_BITS-2:0], cfg_bit}, so the first bit shifted lands in the MSB after CFG_BITS shifts.
REQ-018 The shadow layout, MSB down, SHALL be: for each input j from K-1 to 0, {en_j, sel_j[SW-1:0]}; then trk_sel[W-1:0].
REQ-019 The block SHALL keep a bit counter of $clog2(CFG_BITS+1) bits that increments on each accepted shift and saturates at CFG_BITS.
REQ-020 The FSM SHALL have exactly three states: IDLE, LOAD and COMMIT.
REQ-021 IDLE: a cfg_valid SHALL shift and move to LOAD; a cfg_commit SHALL pulse cfg_err and stay in IDLE.
REQ-022 LOAD: cfg_valid SHALL shift; cfg_commit with count == CFG_BITS SHALL go to COMMIT; cfg_commit with count < CFG_BITS SHALL pulse cfg_err and stay in LOAD.
REQ-023 In the LOAD cycle that accepts cfg_commit, any simultaneous cfg_valid SHALL be ignored.
REQ-024 COMMIT lasts one cycle: active <= shadow, cfg_done = 1, counter cleared, shadow retained, next state IDLE; cfg_valid and cfg_commit SHALL be ignored in this cycle.
REQ-025 cfg_clear SHALL have priority over all other config inputs in every state: shadow <= 0, count <= 0, next state IDLE, active config unchanged, no cfg_done or cfg_err.
REQ-026 Shifts beyond CFG_BITS SHALL keep shifting, with the MSB lost through cfg_out and the count held at CFG_BITS.
REQ-027 cfg_out SHALL equal shadow[CFG_BITS-1], registered, with no combinational path from cfg_bit.
REQ-028 Routing SHALL be combinational from the active config: out[i] = trk_sel[i] ? in[i] : z.
REQ-029 Routing SHALL be combinational from the active config: I[j] = en_j ? in[sel_j] : 0.
REQ-030 A change to in or z SHALL reach out and I in the same cycle; a committed config SHALL take effect in the cycle after the COMMIT cycle.
REQ-031 cfg_done and cfg_err SHALL never be high in the same cycle.

Reset
REQ-032 With reset high at a clock edge, the block SHALL clear active, shadow and counter to 0, enter IDLE, and drive cfg_done = 0, cfg_err = 0, cfg_out = 0.
REQ-033 After reset, out SHALL equal {W{z}} and I SHALL equal 0.
REQ-034 Reset SHALL take priority over cfg_clear, cfg_commit and cfg_valid, including when asserted mid-LOAD or in COMMIT; a partial load SHALL be discarded.

Verification (W=4, K=2, CFG_BITS=10)
REQ-035 Reset, z=1, in=4'b0101 -> out=4'b1111, I=2'b00, cfg_done=0, cfg_err=0.
REQ-036 Shift 1,11, 0,00, 1111 (MSB first), then cfg_commit -> cfg_done pulses once; next cycle in=4'b1000 gives out=4'b1000 and I=2'b10.
REQ-037 Shift 7 bits, then cfg_commit -> cfg_err pulses, active config unchanged; shift 3 more bits, then cfg_commit -> cfg_done pulses.
REQ-038 cfg_clear and cfg_valid together mid-LOAD -> count=0, state IDLE, outputs unchanged; a following cfg_commit -> cfg_err.
REQ-039 Two instances chained (cfg_out to cfg_bit), 20 shifts, then a shared commit -> the first 10 bits land in the far instance and the last 10 in the near instance.
REQ-040 Reset asserted in the COMMIT cycle -> active config = 0, no cfg_done pulse, out={W{z}}.

Source files
------------

// File: rtl/connection_block_gen.sv
// FPGA-style connection block: serially loaded shadow config, committed to an active
// config that steers tracks onto logic-block inputs and z back onto the tracks.
module connection_block_gen #(
   parameter int W = 4,
   parameter int K = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in,
   input  logic         z,
   output logic [W-1:0] out,
   output logic [K-1:0] I,
   input  logic         cfg_valid,
   input  logic         cfg_bit,
   input  logic         cfg_commit,
   input  logic         cfg_clear,
   output logic         cfg_out,
   output logic         cfg_done,
   output logic         cfg_err
);

   localparam int SW       = $clog2(W);
   localparam int CFG_BITS = K * (SW + 1) + W;
   localparam int CW       = $clog2(CFG_BITS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t              state, state_nx;
   logic [CFG_BITS-1:0] shadow, shadow_nx;
   logic [CFG_BITS-1:0] active, active_nx;
   logic [CW-1:0]       count, count_nx;
   logic                done_nx, err_nx;
   logic [CFG_BITS-1:0] shifted;
   logic [CW-1:0]       count_inc;
   logic                count_full;

   assign shifted    = {shadow[CFG_BITS-2:0], cfg_bit};
   assign count_full = (count == CW'(CFG_BITS));
   assign count_inc  = count_full ? count : count + CW'(1);

   always_comb begin
      state_nx  = state;
      shadow_nx = shadow;
      active_nx = active;
      count_nx  = count;
      done_nx   = 1'b0;
      err_nx    = 1'b0;
      if (cfg_clear) begin
         shadow_nx = '0;
         count_nx  = '0;
         state_nx  = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  shadow_nx = shifted;
                  count_nx  = count_inc;
                  state_nx  = LOAD;
               end
               // Nothing is loaded yet, so any commit here is premature.
               if (cfg_commit) err_nx = 1'b1;
            end
            LOAD: begin
               if (cfg_commit) begin
                  if (count_full) state_nx = COMMIT;
                  else            err_nx   = 1'b1;
               end else if (cfg_valid) begin
                  shadow_nx = shifted;
                  count_nx  = count_inc;
               end
            end
            COMMIT: begin
               active_nx = shadow;
               done_nx   = 1'b1;
               count_nx  = '0;
               state_nx  = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         shadow   <= '0;
         active   <= '0;
         count    <= '0;
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= state_nx;
         shadow   <= shadow_nx;
         active   <= active_nx;
         count    <= count_nx;
         cfg_done <= done_nx;
         cfg_err  <= err_nx;
      end
   end

   assign cfg_out = shadow[CFG_BITS-1];

   always_comb begin
      for (int i = 0; i < W; i++) begin
         out[i] = active[i] ? in[i] : z;
      end
   end

   // Input j's field sits above trk_sel: sel in the low SW bits, enable on top.
   always_comb begin
      I = '0;
      for (int j = 0; j < K; j++) begin
         if (active[W + j * (SW + 1) + SW]) I[j] = in[active[W + j * (SW + 1) +: SW]];
      end
   end

endmodule
